control_sequencer: RTL

Microcoded control unit that consumes the 4-bit opcode from the instruction register and drives the CPU control word, including the instruction register's load and address-output-enable strobes. It sits between the instruction register and every bus participant: PC, MAR, RAM, A/B registers, ALU and output register. A step counter walks fetch and execute microsteps, ends each instruction early after its last active step, and latches a halt.

---
 rtl/control_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control unit: T0..T4 step counter, halt latch, control word decode
// Optional JC/JZ opcodes and FI on ADD/SUB are built when CONDITIONAL_JUMP_EN is defined.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  t_state,
  output logic        halted
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  step_t step, step_nxt;
  logic  halt_nxt;
  logic  last;
  logic  hold;
  logic  [15:0] alu_flags;

`ifdef CONDITIONAL_JUMP_EN
  assign alu_flags = C_FI;
`else
  assign alu_flags = 16'h0000;
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step   <= T0;
      halted <= 1'b0;
    end else begin
      step   <= step_nxt;
      halted <= halt_nxt;
    end
  end

  always_comb begin
    ctrl     = 16'h0000;
    last     = 1'b0;
    hold     = 1'b0;
    halt_nxt = halted;
    step_nxt = step;
    if (halted) begin
      ctrl = C_HLT;
      hold = 1'b1;
    end else begin
      case (step)
        T0: ctrl = C_CO | C_MI;
        T1: ctrl = C_RO | C_II | C_CE;
        default: begin
          // Execute steps; an opcode's final step (or any unreachable later one) ends it.
          case (opcode)
            4'b0001: if (step == T2) ctrl = C_IO | C_MI;
                     else begin ctrl = C_RO | C_AI; last = 1'b1; end
            4'b0010, 4'b0011: begin
              case (step)
                T2:      ctrl = C_IO | C_MI;
                T3:      ctrl = C_RO | C_BI;
                default: begin
                  ctrl = C_EO | C_AI | alu_flags | ((opcode == 4'b0011) ? C_SU : 16'h0000);
                  last = 1'b1;
                end
              endcase
            end
            4'b0100: if (step == T2) ctrl = C_IO | C_MI;
                     else begin ctrl = C_AO | C_RI; last = 1'b1; end
            4'b0101: begin ctrl = C_IO | C_AI; last = 1'b1; end
            4'b0110: begin ctrl = C_IO | C_J;  last = 1'b1; end
`ifdef CONDITIONAL_JUMP_EN
            4'b0111: begin ctrl = carry_flag ? (C_IO | C_J) : 16'h0000; last = 1'b1; end
            4'b1000: begin ctrl = zero_flag  ? (C_IO | C_J) : 16'h0000; last = 1'b1; end
`endif
            4'b1110: begin ctrl = C_AO | C_OI; last = 1'b1; end
            4'b1111: begin
              ctrl     = C_HLT;
              halt_nxt = 1'b1;
              hold     = 1'b1;
            end
            default: last = 1'b1;
          endcase
        end
      endcase
    end

    if (!hold) begin
      if (last || step == T4) step_nxt = T0;
      else                    step_nxt = step_t'(step + 3'd1);
    end
  end

  assign t_state = step;

endmodule
